// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, arbiter state encoding and port id helpers for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef enum logic {ST_IDLE, ST_LOCKED} dmem_arb_state_t;
  typedef logic port_id_t;
  function automatic logic [1:0] port_onehot(port_id_t p);
    return {p, ~p};
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side handshake plus data_mem pins for the data-memory arbiter
interface dmem_arbiter_if;
  import dmem_pkg::*;
  logic [1:0] req, we, lock, gnt, rvalid, lock_err;
  logic [ADDR_W-1:0] addr0, addr1, DataAddress;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, DataIn, DataOut;
  logic ReadMem, WriteMem;
  modport master(
    output req, we, lock, addr0, addr1, wdata0, wdata1,
    input gnt, rdata, rvalid, lock_err
  );
  modport slave(
    input req, we, lock, addr0, addr1, wdata0, wdata1, DataOut,
    output gnt, rdata, rvalid, lock_err, DataAddress, ReadMem, WriteMem, DataIn
  );
  modport mem(
    input DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin picker with a forced single-port mode for locks
module dmem_rr_pick import dmem_pkg::*; (
  input  logic [1:0] req,
  input  port_id_t   last,
  input  logic       force_en,
  input  port_id_t   force_id,
  output logic [1:0] gnt
);
  assign gnt = force_en ? (req & port_onehot(force_id)) : (&req) ? port_onehot(~last) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with lock and lock timeout sharing data_mem between LSU and DMA
module dmem_arbiter import dmem_pkg::*; #(
  parameter int LOCK_MAX = 16
) (
  input logic CLK,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  dmem_arb_state_t st, st_nx;
  port_id_t owner, owner_nx, last, last_nx, gp;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] inh, inh_nx, gnt_raw, gnt, rd_gnt, wr_gnt, rvalid_q, lock_err_q;
  logic [DATA_W-1:0] rdata_q;
  logic granted, release_l, timeout;
  dmem_rr_pick u_pick (
    .req(bus.req),
    .last(last),
    .force_en(st == ST_LOCKED),
    .force_id(owner),
    .gnt(gnt_raw)
  );
  assign gnt = reset ? 2'b00 : gnt_raw;
  assign granted = |gnt;
  assign gp = gnt[1];
  assign release_l = (st == ST_LOCKED) && !bus.lock[owner];
  // release takes precedence over a timeout landing in the same cycle
  assign timeout = (st == ST_LOCKED) && !release_l && (cnt + 8'd1 == 8'(LOCK_MAX));
  always_ff @(posedge CLK) begin
    if (reset) begin
      st <= ST_IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      inh <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
      lock_err_q <= '0;
    end else begin
      st <= st_nx;
      owner <= owner_nx;
      last <= last_nx;
      cnt <= cnt_nx;
      inh <= inh_nx;
      rvalid_q <= rd_gnt;
      rdata_q <= (|rd_gnt) ? bus.DataOut : rdata_q;
      lock_err_q <= timeout ? port_onehot(owner) : 2'b00;
    end
  end
  // a timed-out owner may not re-lock until it shows lock=0 for a cycle
  always_comb begin
    st_nx = st;
    owner_nx = owner;
    cnt_nx = '0;
    last_nx = granted ? gp : last;
    inh_nx = inh & bus.lock;
    if (st == ST_IDLE) begin
      if (granted && bus.lock[gp] && !inh[gp]) begin
        st_nx = ST_LOCKED;
        owner_nx = gp;
      end
    end else if (release_l) begin
      st_nx = ST_IDLE;
    end else if (timeout) begin
      st_nx = ST_IDLE;
      last_nx = owner;
      inh_nx[owner] = 1'b1;
    end else begin
      cnt_nx = cnt + 8'd1;
    end
  end
  always_comb begin
    rd_gnt = gnt & ~bus.we;
    wr_gnt = gnt & bus.we;
    bus.gnt = gnt;
    bus.DataAddress = gnt[0] ? bus.addr0 : gnt[1] ? bus.addr1 : '0;
    bus.ReadMem = |rd_gnt;
    bus.WriteMem = |wr_gnt;
    bus.DataIn = wr_gnt[0] ? bus.wdata0 : wr_gnt[1] ? bus.wdata1 : '0;
    bus.rvalid = rvalid_q;
    bus.rdata = rdata_q;
    bus.lock_err = lock_err_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a cycle-level reference model and hand-computed expectations
module tb_dmem_arbiter;
  localparam int LOCK_MAX = 4;
  logic CLK = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  dmem_arbiter_if bus();
  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_val(int i);
    return i == 16 ? 8'd254 : i == 244 ? 8'd5 : 8'(i * 3 + 1);
  endfunction

  logic [7:0] mem [256];
  logic mem_ready = 1'b0;
  always @(posedge CLK)
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (bus.WriteMem) mem[bus.DataAddress] <= bus.DataIn;
  assign bus.DataOut = mem[bus.DataAddress];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  logic [7:0] ref_mem [256];
  logic ref_init = 1'b0;
  logic m_locked = 1'b0, m_owner = 1'b0, m_last = 1'b1;
  int m_held = 0;
  logic [1:0] m_inh = 2'b00, m_rvalid = 2'b00, m_lerr = 2'b00;
  logic [7:0] m_rdata = 8'd0;

  always @(negedge CLK) begin
    logic [1:0] eg;
    logic g, p, rd, wr;
    logic [7:0] ea, ed;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_init = 1'b1;
    end
    chk("model_rvalid", bus.rvalid, m_rvalid);
    chk("model_rdata", bus.rdata, m_rdata);
    chk("model_lock_err", bus.lock_err, m_lerr);
    if (reset) eg = 2'b00;
    else if (m_locked) eg = bus.req[m_owner] ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    else if (bus.req == 2'b11) eg = m_last ? 2'b01 : 2'b10;
    else eg = bus.req;
    g = eg != 2'b00;
    p = eg[1];
    rd = g && !bus.we[p];
    wr = g && bus.we[p];
    ea = !g ? 8'd0 : p ? bus.addr1 : bus.addr0;
    ed = !wr ? 8'd0 : p ? bus.wdata1 : bus.wdata0;
    chk("model_gnt", bus.gnt, eg);
    chk("model_addr", bus.DataAddress, ea);
    chk("model_readmem", bus.ReadMem, rd);
    chk("model_writemem", bus.WriteMem, wr);
    if (!rd) chk("model_datain", bus.DataIn, ed);
    if (reset) begin
      m_locked = 1'b0; m_last = 1'b1; m_held = 0; m_inh = 2'b00;
      m_rvalid = 2'b00; m_rdata = 8'd0; m_lerr = 2'b00;
    end else begin
      m_lerr = 2'b00;
      m_rvalid = rd ? eg : 2'b00;
      if (rd) m_rdata = ref_mem[ea];
      if (wr) ref_mem[ea] = ed;
      for (int q = 0; q < 2; q++) if (!bus.lock[q]) m_inh[q] = 1'b0;
      if (g) m_last = p;
      if (m_locked) begin
        if (!bus.lock[m_owner]) m_locked = 1'b0;
        else if (m_held + 1 == LOCK_MAX) begin
          m_locked = 1'b0;
          m_lerr = m_owner ? 2'b10 : 2'b01;
          m_inh[m_owner] = 1'b1;
          m_last = m_owner;
        end else m_held++;
      end else if (g && bus.lock[p] && !m_inh[p]) begin
        m_locked = 1'b1;
        m_owner = p;
        m_held = 0;
      end
    end
  end

  task automatic cyc(input logic rst_v, input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                     input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    @(posedge CLK);
    #1;
    reset = rst_v; bus.req = r; bus.we = w; bus.lock = l;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    @(negedge CLK);
  endtask

  initial begin
    reset = 1'b1; bus.req = 0; bus.we = 0; bus.lock = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    cyc(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_rvalid", bus.rvalid, 2'b00);
    chk("rst_rdata", bus.rdata, 8'd0);
    chk("rst_lock_err", bus.lock_err, 2'b00);
    // tie after reset goes to port 0
    cyc(0, 2'b11, 2'b00, 2'b00, 16, 244, 0, 0);
    chk("tie_gnt0", bus.gnt, 2'b01);
    cyc(0, 2'b10, 2'b00, 2'b00, 16, 244, 0, 0);
    chk("tie_gnt1", bus.gnt, 2'b10);
    chk("tie_rvalid0", bus.rvalid, 2'b01);
    chk("tie_rdata0", bus.rdata, 8'd254);
    cyc(0, 2'b00, 2'b00, 2'b00, 16, 244, 0, 0);
    chk("tie_rvalid1", bus.rvalid, 2'b10);
    chk("tie_rdata1", bus.rdata, 8'd5);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
      chk("rr_gnt", bus.gnt, i % 2 == 0 ? 2'b01 : 2'b10);
      chk("rr_onehot", $countones(bus.gnt), 1);
    end
    // locked read-modify-write by port 1
    cyc(0, 2'b10, 2'b00, 2'b10, 32, 16, 0, 0);
    chk("rmw_lock_gnt", bus.gnt, 2'b10);
    cyc(0, 2'b01, 2'b00, 2'b10, 16, 16, 0, 0);
    chk("rmw_stall_gnt", bus.gnt, 2'b00);
    chk("rmw_stall_addr", bus.DataAddress, 8'd0);
    chk("rmw_read_rdata", bus.rdata, 8'd254);
    cyc(0, 2'b11, 2'b10, 2'b00, 16, 16, 0, 255);
    chk("rmw_write_gnt", bus.gnt, 2'b10);
    chk("rmw_write_we", bus.WriteMem, 1'b1);
    chk("rmw_write_din", bus.DataIn, 8'd255);
    cyc(0, 2'b01, 2'b00, 2'b00, 16, 16, 0, 0);
    chk("rmw_p0_gnt", bus.gnt, 2'b01);
    cyc(0, 2'b00, 2'b00, 2'b00, 16, 16, 0, 0);
    chk("rmw_p0_rdata", bus.rdata, 8'd255);
    // abandoned request while port 1 holds the lock
    cyc(0, 2'b10, 2'b00, 2'b10, 0, 5, 0, 0);
    chk("ab_lock_gnt", bus.gnt, 2'b10);
    cyc(0, 2'b01, 2'b00, 2'b10, 9, 5, 0, 0);
    chk("ab_stall_gnt", bus.gnt, 2'b00);
    chk("ab_pins", {bus.DataAddress, bus.ReadMem, bus.WriteMem, bus.DataIn}, 0);
    cyc(0, 2'b00, 2'b00, 2'b10, 9, 5, 0, 0);
    chk("ab_idle_gnt", bus.gnt, 2'b00);
    cyc(0, 2'b10, 2'b00, 2'b00, 9, 5, 0, 0);
    chk("ab_release_gnt", bus.gnt, 2'b10);
    cyc(0, 2'b00, 2'b00, 2'b00, 9, 5, 0, 0);
    // lock timeout of port 0
    cyc(0, 2'b01, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_acq_gnt", bus.gnt, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 2'b11, 2'b00, 2'b01, 7, 9, 0, 0);
      chk("to_held_gnt", bus.gnt, 2'b01);
      chk("to_held_err", bus.lock_err, 2'b00);
    end
    cyc(0, 2'b11, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_err", bus.lock_err, 2'b01);
    chk("to_p1_gnt", bus.gnt, 2'b10);
    cyc(0, 2'b01, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_err_clear", bus.lock_err, 2'b00);
    chk("to_p0_gnt", bus.gnt, 2'b01);
    cyc(0, 2'b11, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_no_relock", bus.gnt, 2'b10);
    cyc(0, 2'b01, 2'b00, 2'b00, 7, 9, 0, 0);
    chk("to_drop_gnt", bus.gnt, 2'b01);
    cyc(0, 2'b01, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_relock_gnt", bus.gnt, 2'b01);
    cyc(0, 2'b11, 2'b00, 2'b01, 7, 9, 0, 0);
    chk("to_relocked", bus.gnt, 2'b01);
    cyc(0, 2'b11, 2'b00, 2'b00, 7, 9, 0, 0);
    chk("to_release", bus.gnt, 2'b01);
    cyc(0, 2'b10, 2'b00, 2'b00, 7, 9, 0, 0);
    chk("to_after", bus.gnt, 2'b10);
    cyc(0, 2'b00, 2'b00, 2'b00, 7, 9, 0, 0);
    // reset while port 1 is locked mid-write
    cyc(0, 2'b10, 2'b10, 2'b10, 0, 50, 0, 77);
    chk("rl_gnt", bus.gnt, 2'b10);
    cyc(1, 2'b10, 2'b10, 2'b10, 0, 51, 0, 88);
    chk("rl_gnt_rst", bus.gnt, 2'b00);
    chk("rl_we_rst", bus.WriteMem, 1'b0);
    chk("rl_pins_rst", {bus.DataAddress, bus.ReadMem, bus.DataIn}, 0);
    cyc(0, 2'b11, 2'b00, 2'b00, 51, 50, 0, 0);
    chk("rl_no_err", bus.lock_err, 2'b00);
    chk("rl_rvalid", bus.rvalid, 2'b00);
    chk("rl_rdata", bus.rdata, 8'd0);
    chk("rl_idle_gnt", bus.gnt, 2'b01);
    cyc(0, 2'b10, 2'b00, 2'b00, 51, 50, 0, 0);
    chk("rl_unwritten", bus.rdata, 8'd154);
    cyc(0, 2'b00, 2'b00, 2'b00, 51, 50, 0, 0);
    chk("rl_written", bus.rdata, 8'd77);
    chk("rl_written_rvalid", bus.rvalid, 2'b10);
    cyc(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-pointer 256×8 data memory (`data_mem`) between the core's load/store unit (port 0) and the block-copy/DMA engine (port 1). It performs round-robin arbitration with an optional lock for atomic multi-cycle sequences such as read-modify-write. It drives the memory's address, read-enable, write-enable and write-data pins, and returns registered read data to the winning port. It sits directly between the requesters and `data_mem`; no other block may drive the memory pins.

## Interface
Parameters:
- `LOCK_MAX`, default 16: maximum consecutive cycles one port may hold a lock before forced release; range 1–255.

Ports:
- `CLK`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req[1:0]`  in  2  per-port access request.
- `we[1:0]`  in  2  per-port write (1) / read (0) select; qualified by `req`.
- `lock[1:0]`  in  2  per-port lock request; qualified by `req`.
- `addr0`, `addr1`  in  8  per-port byte address.
- `wdata0`, `wdata1`  in  8  per-port write data.
- `gnt[1:0]`  out  2  one-hot grant for the current cycle; combinational.
- `rdata`  out  8  read data, registered.
- `rvalid[1:0]`  out  2  one-hot: `rdata` is valid for this port; registered.
- `lock_err[1:0]`  out  2  one-cycle pulse when a port's lock is force-released; registered.
- `DataAddress`  out  8  to memory.
- `ReadMem`  out  1  to memory.
- `WriteMem`  out  1  to memory.
- `DataIn`  out  8  to memory.
- `DataOut`  in  8  from memory; combinational read data.

## Operation
- **Arbitration.** Each cycle, at most one port is granted.
  - If only one port requests, that port wins.
  - If both request, the port that was *not* granted most recently wins (pointer `last`).
  - `last` updates at the clock edge to the granted port, only when a grant occurs.
- **Lock.**
  - If the granted port has `lock=1`, the arbiter enters LOCKED with `owner` set to that port.
  - While LOCKED, only `owner` can be granted. The other port's `req` is stalled (`gnt=0`) even if `owner` is idle that cycle.
  - LOCKED exits at the edge after a cycle in which `owner` presents `req=1, lock=0` (that access still completes), or `req=0, lock=0`.
- **Lock timeout.**
  - An 8-bit counter counts cycles spent in LOCKED.
  - When the count reaches `LOCK_MAX`, the arbiter returns to IDLE at that edge, pulses `lock_err[owner]` for one cycle, and sets `last=owner`.
  - That port cannot re-lock until it has been through one cycle with `lock=0`.
- **States:**
  - `IDLE → LOCKED`: on a granted request with `lock=1`.
  - `LOCKED → IDLE`: on release or timeout.
- **Memory drive** (combinational from the grant):
  - Granted read: `DataAddress=addrN`, `ReadMem=1`, `WriteMem=0`.
  - Granted write: `DataAddress=addrN`, `DataIn=wdataN`, `WriteMem=1`, `ReadMem=0`.
  - No grant: all four memory outputs are 0.
- **Read return.** On a granted read, `DataOut` is captured into `rdata` at the edge, with `rvalid[N]=1` for one cycle.
  - `rdata` holds its value when `rvalid=0`.
- **Writes.** No response; the write commits at the edge ending the grant cycle.

## Timing
- Grant and memory pins: 0-cycle latency (same cycle as `req`).
- Read data: `rvalid`/`rdata` one cycle after grant.
- Write-then-read at the same address in consecutive cycles, from either port, returns the new data.
- Requesters must hold `req`, `addr`, `we` and `wdata` stable until they see `gnt`.
- A requester may drop `req` without having been granted; no state is affected.
- **Reset values:**
  - `gnt=0`, `rvalid=0`, `rdata=0`, `lock_err=0`.
  - Memory outputs = 0.
  - `last=1`, so port 0 wins the first tie.
  - State = IDLE, lock counter = 0.
- Reset asserted mid-lock aborts the lock immediately, with no `lock_err`.
  - Memory writes are suppressed while `reset` is high (`WriteMem=0`).
- With `LOCK_MAX=1`, a lock lasts exactly one locked cycle beyond the acquiring access.

## Structure
- Package `dmem_pkg`:
  - `ADDR_W=8`, `DATA_W=8`.
  - `typedef enum logic {ST_IDLE, ST_LOCKED} dmem_arb_state_t`.
  - `typedef logic port_id_t` (0 = LSU, 1 = DMA).
- Sub-module `dmem_rr_pick`: combinational two-way round-robin picker with inputs `req[1:0]`, `last`, `force_en`, `force_id`, and output `gnt[1:0]`.
- Remaining logic lives in `dmem_arbiter`: state register, lock counter, re-lock inhibit flags, read-return register, and pin muxing.

## Test plan
1. **Tie-break after reset.** Both ports read at cycle 0 (`addr0=16`, `addr1=244`) with a `data_mem` whose reset contents are `M[16]=254`, `M[244]=5`.
   - Required: port 0 granted at cycle 0 and port 1 at cycle 1.
   - Required: `rdata` 254 with `rvalid=01`, then 5 with `rvalid=10`.
2. **Round-robin.** Both ports hold `req` continuously for 6 cycles.
   - Required: grants alternate 01, 10, 01, 10, 01, 10.
   - Required: exactly one `gnt` bit set each cycle.
3. **Locked read-modify-write.** Port 1 locks, reads `M[16]`, writes 255; port 0 requests throughout.
   - Required: port 0 is stalled until the unlocked write completes.
   - Required: port 0's subsequent read returns 255.
4. **Lock timeout.** With `LOCK_MAX=4`, port 0 holds `lock=1` and `req=1` indefinitely.
   - Required: `lock_err=01` pulses after 4 locked cycles.
   - Required: port 1 is granted the next cycle.
   - Required: port 0 does not regain LOCKED until it drops `lock`.
5. **Reset mid-lock.** Assert `reset` while port 1 is locked mid-write.
   - Required: `WriteMem=0` during reset, state IDLE, all outputs 0.
   - Required: no `lock_err` pulse.
6. **Idle and abandoned request.** Port 0 raises `req` for one cycle while port 1 is locked, then drops it.
   - Required: no grant to port 0.
   - Required: memory pins stay 0 on cycles where `owner` is idle.
